bpv_stream_reader: RTL and testbench
====================================

BPV_STREAM_READER -- requirements
Module: bpv_stream_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 128, width of one write/read word.
REQ-002 SHALL have parameter WORDS, default 32, words per polynomial region.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mode  input  1  0=encryption (Bp0,Bp1,V), 1=decryption (Mp only).
REQ-006 SHALL have port wr_valid  input  1  write strobe from PAcc stage (outready).
REQ-007 SHALL have port wr_addr  input  8  write address: 32-63 Bp0, 64-95 Bp1, 128-159 V/Mp.
REQ-008 SHALL have port wr_data  input  WORD_W  write word.
REQ-009 SHALL have port rd_ready  input  1  downstream accepts rd_data.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid.
REQ-011 SHALL have port rd_data  output  WORD_W  drained word.
REQ-012 SHALL have port rd_region  output  2  region of rd_data: 0=Bp0, 1=Bp1, 2=V/Mp.
REQ-013 SHALL have port rd_index  output  5  word index within region.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last word of frame accepted.
REQ-015 SHALL have port err_addr  output  1  sticky: write to undecoded address.
REQ-016 SHALL have port err_overrun  output  1  sticky: write to already-full region.

Function
REQ-017 SHALL store words in a 3x32xWORD_W buffer; index = wr_addr minus region base (32, 64, 128).
REQ-018 SHALL keep a 32-bit written-vector per region; set bit on an accepted write; region full when all 32 bits are set.
REQ-019 SHALL accept writes in any order; a rewrite of an index in a non-full region overwrites data and leaves the vector unchanged.
REQ-020 SHALL drop writes with wr_valid=1 and addr outside the three ranges, and set err_addr.
REQ-021 SHALL drop writes to a full region, and set err_overrun; buffer contents stay unchanged.
REQ-022 SHALL implement states IDLE, WAIT_BP0, DRAIN_BP0, WAIT_BP1, DRAIN_BP1, WAIT_V, DRAIN_V, DONE.
REQ-023 SHALL leave IDLE on the first decoded wr_valid and latch mode on that cycle. Enc goes to WAIT_BP0; dec goes to WAIT_V.
REQ-024 SHALL move from WAIT_x to DRAIN_x on the cycle after region x becomes full, or on the same cycle if x was already full on entry.
REQ-025 In enc mode SHALL drain in the order Bp0, Bp1, V. V, written first by upstream, is held until Bp1 has drained.
REQ-026 In dec mode SHALL drain V/Mp only; Bp writes in dec mode are stored and cleared at frame end without being output.
REQ-027 SHALL assert rd_valid exactly 2 cycles after the edge entering DRAIN_x, because of the registered buffer read.
REQ-028 SHALL present indices 0..31 in ascending order.
REQ-029 SHALL hold rd_valid, rd_data, rd_region and rd_index stable while rd_valid=1 and rd_ready=0.
REQ-030 SHALL transfer on rd_valid&&rd_ready and SHALL sustain one word per cycle while rd_ready stays high.
REQ-031 After index 31 transfers SHALL deassert rd_valid on the next cycle unless the next region's word 0 is presented; back-to-back drain between regions is not required.
REQ-032 After the last word of the frame transfers SHALL enter DONE, pulse frame_done for one cycle, clear all written-vectors, and return to IDLE.
REQ-033 SHALL accept writes in DONE and IDLE into the cleared vectors; those writes belong to the next frame.
REQ-034 mode changes after the latch point SHALL have no effect until the next IDLE exit.

Reset
REQ-035 While rst_n=0 at a clock edge: state=IDLE, vectors cleared, rd_valid=0, rd_data=0, rd_region=0, rd_index=0, frame_done=0, err_addr=0, err_overrun=0.
REQ-036 Reset mid-drain SHALL abandon the frame; buffer data is don't-care; no frame_done.
REQ-037 Error flags SHALL clear only on reset.

Verification
REQ-038 Enc frame: V words 128-159, then Bp0 32-63, then Bp1 64-95, each data=addr pattern, rd_ready=1 -> 96 words out in order Bp0, Bp1, V with matching data; frame_done pulses once.
REQ-039 Dec frame: mode=1, writes 128-159 -> exactly 32 words with rd_region=2, then frame_done; no Bp output.
REQ-040 Backpressure: rd_ready toggles 1,0,0,1 pseudo-randomly -> no word lost or duplicated; outputs stable while stalled.
REQ-041 Errors: write addr 100 -> err_addr=1, no buffer change; 33rd write to a full Bp0 -> err_overrun=1, data unchanged.
REQ-042 Out-of-order Bp0 writes (31 down to 0) -> drain still ascending 0..31; first rd_valid exactly 2 cycles after DRAIN_BP0 entry.
REQ-043 Reset asserted after 10 Bp0 words are drained -> all outputs 0 next cycle; a fresh full enc frame afterwards completes correctly.

Source files
------------

// File: rtl/bpv_stream_reader.sv
// bpv_stream_reader: collects the Bp0, Bp1 and V/Mp polynomial regions written
// by the PAcc stage into a buffer, then streams them out word by word over a
// valid/ready port. Encryption frames drain Bp0, Bp1, V in that order;
// decryption frames drain V/Mp only.
module bpv_stream_reader #(
  parameter int WORD_W = 128,
  parameter int WORDS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              wr_valid,
  input  logic [7:0]        wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic [1:0]        rd_region,
  output logic [4:0]        rd_index,
  output logic              frame_done,
  output logic              err_addr,
  output logic              err_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BP0,
    DRAIN_BP0,
    WAIT_BP1,
    DRAIN_BP1,
    WAIT_V,
    DRAIN_V,
    DONE
  } state_t;

  localparam logic [7:0] BASE_BP0 = 8'd32;
  localparam logic [7:0] BASE_BP1 = 8'd64;
  localparam logic [7:0] BASE_V   = 8'd128;
  localparam logic [8:0] SPAN     = 9'(WORDS);
  localparam logic [5:0] ISSUE_END = 6'(WORDS);
  localparam logic [4:0] LAST_IDX  = 5'(WORDS - 1);

  state_t r_state;
  state_t w_nextState;

  logic [WORD_W-1:0] r_mem [3][WORDS];
  logic [WORDS-1:0]  r_vec [3];

  logic              w_decoded;
  logic [1:0]        w_wrRegion;
  logic [4:0]        w_wrIdx;
  logic              w_wrFull;
  logic              w_wrHit;
  logic              w_wrAccept;

  logic              w_draining;
  logic [1:0]        w_drainRegion;
  logic              w_adv;
  logic              w_issue;
  logic              w_fire;
  logic              w_lastXfer;

  logic [5:0]        r_issueCnt;
  logic              r_s1Valid;
  logic [1:0]        r_s1Region;
  logic [4:0]        r_s1Index;
  logic [WORD_W-1:0] r_s1Data;

  logic              r_rdValid;
  logic [1:0]        r_rdRegion;
  logic [4:0]        r_rdIndex;
  logic [WORD_W-1:0] r_rdData;
  logic              r_errAddr;
  logic              r_errOverrun;

  // Decode the write address into a region and an index relative to its base.
  always_comb begin
    w_decoded  = 1'b1;
    w_wrRegion = 2'd0;
    w_wrIdx    = 5'd0;
    if (wr_addr >= BASE_BP0 && {1'b0, wr_addr} < ({1'b0, BASE_BP0} + SPAN)) begin
      w_wrRegion = 2'd0;
      w_wrIdx    = 5'(wr_addr - BASE_BP0);
    end else if (wr_addr >= BASE_BP1 && {1'b0, wr_addr} < ({1'b0, BASE_BP1} + SPAN)) begin
      w_wrRegion = 2'd1;
      w_wrIdx    = 5'(wr_addr - BASE_BP1);
    end else if (wr_addr >= BASE_V && {1'b0, wr_addr} < ({1'b0, BASE_V} + SPAN)) begin
      w_wrRegion = 2'd2;
      w_wrIdx    = 5'(wr_addr - BASE_V);
    end else begin
      w_decoded  = 1'b0;
    end
  end

  // A region counts as full only while its vector is complete; in DONE the
  // vectors are being cleared, so writes there start the next frame.
  always_comb begin
    w_wrFull = 1'b0;
    if (r_state != DONE) begin
      case (w_wrRegion)
        2'd0:    w_wrFull = &r_vec[0];
        2'd1:    w_wrFull = &r_vec[1];
        default: w_wrFull = &r_vec[2];
      endcase
    end
  end

  assign w_wrHit    = wr_valid && w_decoded;
  assign w_wrAccept = w_wrHit && !w_wrFull;

  assign w_draining    = (r_state == DRAIN_BP0) || (r_state == DRAIN_BP1) ||
                         (r_state == DRAIN_V);
  assign w_drainRegion = (r_state == DRAIN_BP1) ? 2'd1 :
                         (r_state == DRAIN_V)   ? 2'd2 : 2'd0;

  // The whole read pipeline moves together whenever the output slot is free
  // or being consumed, so a stall freezes every stage in place.
  assign w_fire     = r_rdValid && rd_ready;
  assign w_adv      = !r_rdValid || rd_ready;
  assign w_issue    = w_draining && (r_issueCnt != ISSUE_END) && w_adv;
  assign w_lastXfer = w_fire && (r_rdIndex == LAST_IDX);

  // Buffer storage; contents need no reset because the vectors qualify them.
  always_ff @(posedge clk) begin
    if (w_wrAccept) begin
      r_mem[w_wrRegion][w_wrIdx] <= wr_data;
    end
  end

  // Written-vectors: set on accepted writes, wiped when a frame completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) r_vec[r] <= '0;
    end else begin
      if (r_state == DONE) begin
        for (int r = 0; r < 3; r++) r_vec[r] <= '0;
      end
      if (w_wrAccept) begin
        r_vec[w_wrRegion][w_wrIdx] <= 1'b1;
      end
    end
  end

  // Sticky error flags for dropped writes; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_errAddr    <= 1'b0;
      r_errOverrun <= 1'b0;
    end else begin
      if (wr_valid && !w_decoded) r_errAddr <= 1'b1;
      if (w_wrHit && w_wrFull)    r_errOverrun <= 1'b1;
    end
  end

  // Frame sequencing register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; mode only matters on the IDLE exit, where the chosen
  // path itself is the latched mode for the rest of the frame.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (w_wrHit)     w_nextState = mode ? WAIT_V : WAIT_BP0;
      WAIT_BP0:  if (&r_vec[0])   w_nextState = DRAIN_BP0;
      DRAIN_BP0: if (w_lastXfer)  w_nextState = WAIT_BP1;
      WAIT_BP1:  if (&r_vec[1])   w_nextState = DRAIN_BP1;
      DRAIN_BP1: if (w_lastXfer)  w_nextState = WAIT_V;
      WAIT_V:    if (&r_vec[2])   w_nextState = DRAIN_V;
      DRAIN_V:   if (w_lastXfer)  w_nextState = DONE;
      DONE:                       w_nextState = IDLE;
      default:                    w_nextState = IDLE;
    endcase
  end

  // Two-stage drain: registered buffer read, then the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issueCnt <= 6'd0;
      r_s1Valid  <= 1'b0;
      r_s1Region <= 2'd0;
      r_s1Index  <= 5'd0;
      r_s1Data   <= '0;
      r_rdValid  <= 1'b0;
      r_rdRegion <= 2'd0;
      r_rdIndex  <= 5'd0;
      r_rdData   <= '0;
    end else begin
      if (!w_draining)  r_issueCnt <= 6'd0;
      else if (w_issue) r_issueCnt <= r_issueCnt + 6'd1;
      if (w_adv) begin
        r_s1Valid  <= w_issue;
        r_s1Region <= w_drainRegion;
        r_s1Index  <= r_issueCnt[4:0];
        r_s1Data   <= r_mem[w_drainRegion][r_issueCnt[4:0]];
        r_rdValid  <= r_s1Valid;
        r_rdRegion <= r_s1Region;
        r_rdIndex  <= r_s1Index;
        r_rdData   <= r_s1Data;
      end
    end
  end

  assign rd_valid    = r_rdValid;
  assign rd_data     = r_rdData;
  assign rd_region   = r_rdRegion;
  assign rd_index    = r_rdIndex;
  assign frame_done  = (r_state == DONE);
  assign err_addr    = r_errAddr;
  assign err_overrun = r_errOverrun;

endmodule

// File: tb/tb_bpv_stream_reader.sv
// tb_bpv_stream_reader: directed frame sequence with randomized data, write
// order and backpressure, checked against a region/vector model of the buffer.
module tb_bpv_stream_reader;

   localparam int WORD_W = 128;
   localparam int WORDS  = 32;
   localparam int CW     = WORD_W + 8;

   typedef logic [WORD_W+6:0] item_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mode;
   logic              wr_valid;
   logic [7:0]        wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              rd_ready;
   logic              rd_valid;
   logic [WORD_W-1:0] rd_data;
   logic [1:0]        rd_region;
   logic [4:0]        rd_index;
   logic              frame_done;
   logic              err_addr;
   logic              err_overrun;

   int checkCount = 0;
   int passCount  = 0;
   int doneCount  = 0;
   bit randomReady = 1'b0;

   item_t capQ[$];
   item_t expQ[$];
   bit    stalled = 1'b0;
   logic [CW-1:0] heldItem;

   logic [WORD_W-1:0] modelMem [3][WORDS];
   bit   [WORDS-1:0]  modelVec [3];
   bit                expErrAddr;
   bit                expErrOver;

   bpv_stream_reader #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .wr_valid(wr_valid),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_region(rd_region),
      .rd_index(rd_index), .frame_done(frame_done), .err_addr(err_addr),
      .err_overrun(err_overrun)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [CW-1:0] observed,
                              input logic [CW-1:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   function automatic int regionBase(input int r);
      return (r == 0) ? 32 : (r == 1) ? 64 : 128;
   endfunction

   function automatic logic [WORD_W-1:0] randWord();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Buffer model: decode, drop undecoded or full-region writes, else store.
   function automatic void modelWrite(input logic [7:0] addr, input logic [WORD_W-1:0] data);
      int a = int'(addr);
      int r = -1;
      for (int k = 0; k < 3; k++)
         if (a >= regionBase(k) && a < regionBase(k) + WORDS) r = k;
      if (r < 0) expErrAddr = 1'b1;
      else if (&modelVec[r]) expErrOver = 1'b1;
      else begin
         modelMem[r][a - regionBase(r)] = data;
         modelVec[r][a - regionBase(r)] = 1'b1;
      end
   endfunction

   function automatic void modelReset();
      for (int r = 0; r < 3; r++) modelVec[r] = '0;
      expErrAddr = 1'b0;
      expErrOver = 1'b0;
   endfunction

   // One write cycle on the PAcc side, mirrored into the model.
   task automatic applyStimulus(input logic [7:0] addr, input logic [WORD_W-1:0] data);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_data  = data;
      modelWrite(addr, data);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic writeRegionOrdered(input int r, input bit addrPattern);
      for (int i = 0; i < WORDS; i++) begin
         logic [7:0] a = 8'(regionBase(r) + i);
         applyStimulus(a, addrPattern ? WORD_W'(a) : randWord());
      end
   endtask

   // Random index order with repeats until the model says the region is full.
   task automatic writeRegionRandom(input int r);
      for (int guard = 0; guard < 4000 && !(&modelVec[r]); guard++) begin
         int idx = int'($urandom_range(0, WORDS - 1));
         applyStimulus(8'(regionBase(r) + idx), randWord());
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_data"}, CW'(rd_data), '0);
      checkOutput({tag, "_ctrl"}, CW'({rd_valid, rd_region, rd_index, frame_done, err_addr, err_overrun}), '0);
   endtask

   // Wait for the frame to finish and compare the drained stream to the model.
   task automatic endFrame(input string tag, input bit isDec);
      expQ.delete();
      for (int r = (isDec ? 2 : 0); r < 3; r++)
         for (int i = 0; i < WORDS; i++)
            expQ.push_back({2'(r), 5'(i), modelMem[r][i]});
      for (int k = 0; k < 4000 && doneCount == 0; k++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      checkOutput({tag, "_doneCount"}, CW'(doneCount), CW'(1));
      checkOutput({tag, "_wordCount"}, CW'(capQ.size()), CW'(expQ.size()));
      for (int i = 0; i < expQ.size(); i++)
         checkOutput($sformatf("%s_word%0d", tag, i),
                     (i < capQ.size()) ? CW'(capQ[i]) : {CW{1'bx}}, CW'(expQ[i]));
      checkOutput({tag, "_idleValid"}, CW'(rd_valid), CW'(0));
      for (int r = 0; r < 3; r++) modelVec[r] = '0;
      capQ.delete();
      doneCount = 0;
   endtask

   // Backpressure generator, changing rd_ready just after each rising edge.
   initial begin
      rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rd_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: records transfers, counts frame_done, checks stall hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled)
            checkOutput("stallHold", CW'({rd_valid, rd_region, rd_index, rd_data}), heldItem);
         if (rd_valid && rd_ready) capQ.push_back({rd_region, rd_index, rd_data});
         if (frame_done) doneCount++;
         stalled  = rd_valid && !rd_ready;
         heldItem = CW'({rd_valid, rd_region, rd_index, rd_data});
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed frame sequence.
   initial begin
      int lat;
      rst_n    = 1'b0;
      mode     = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = 8'd0;
      wr_data  = '0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] encryption frame, address-pattern data, no backpressure");
      writeRegionOrdered(2, 1'b1);
      writeRegionOrdered(0, 1'b1);
      writeRegionOrdered(1, 1'b1);
      endFrame("enc", 1'b0);
      checkOutput("encErrFlags", CW'({err_addr, err_overrun}), CW'(0));

      $display("[TB] decryption frame with late mode change and Bp writes");
      randomReady = 1'b1;
      mode = 1'b1;
      applyStimulus(8'd128, randWord());
      mode = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(8'(32 + i), randWord());
      applyStimulus(8'd64, randWord());
      writeRegionRandom(2);
      endFrame("dec", 1'b1);

      $display("[TB] encryption frame, random order with rewrites, backpressure");
      writeRegionRandom(2);
      writeRegionRandom(0);
      writeRegionRandom(1);
      endFrame("bp", 1'b0);
      checkOutput("bpErrFlags", CW'({err_addr, err_overrun}), CW'(0));

      $display("[TB] error frame: undecoded address and overrun");
      applyStimulus(8'd100, randWord());
      checkOutput("errAddrSet", CW'({err_addr, err_overrun}), CW'({expErrAddr, expErrOver}));
      writeRegionOrdered(0, 1'b0);
      applyStimulus(8'd40, randWord());
      checkOutput("errOverrunSet", CW'({err_addr, err_overrun}), CW'({expErrAddr, expErrOver}));
      checkOutput("errBothModel", CW'({expErrAddr, expErrOver}), CW'(2'b11));
      writeRegionRandom(1);
      writeRegionRandom(2);
      endFrame("err", 1'b0);
      checkOutput("errSticky", CW'({err_addr, err_overrun}), CW'(2'b11));

      $display("[TB] descending Bp0 writes and first-word latency");
      randomReady = 1'b0;
      for (int i = WORDS - 1; i >= 0; i--) applyStimulus(8'(32 + i), randWord());
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (lat == 0 && rd_valid) lat = k;
      end
      checkOutput("firstValidLatency", CW'(lat), CW'(3));
      writeRegionOrdered(1, 1'b0);
      writeRegionRandom(2);
      endFrame("ooo", 1'b0);

      $display("[TB] reset in the middle of the Bp0 drain");
      randomReady = 1'b1;
      writeRegionRandom(0);
      for (int k = 0; k < 1000 && capQ.size() < 10; k++) @(posedge clk);
      #1;
      checkOutput("drainedTen", CW'(capQ.size() >= 10), CW'(1));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkResetOutputs("midReset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      capQ.delete();
      doneCount = 0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("noDoneAfterReset", CW'(doneCount), CW'(0));
      checkOutput("noWordsAfterReset", CW'(capQ.size()), CW'(0));
      writeRegionRandom(2);
      writeRegionRandom(0);
      writeRegionRandom(1);
      endFrame("postReset", 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
